fc_layer: RTL
=============

FC_LAYER -- requirements
Module: fc_layer

Interface
REQ-001 SHALL have parameter IN_LEN, default 9, meaning number of inputs per neuron (pooled 3x3 map, flattened row-major).
REQ-002 SHALL have parameter OUT_LEN, default 4, meaning number of output neurons.
REQ-003 SHALL have parameter FRAC, default 8, meaning fractional bits of the signed fixed-point format.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1, meaning begin one inference pass.
REQ-007 SHALL have port input_fm, input, signed 32 x IN_LEN, meaning the pooled feature map.
REQ-008 SHALL have port w_we, input, 1, meaning parameter write enable.
REQ-009 SHALL have port w_addr, input, 6, meaning parameter address: weights at j*IN_LEN+k, then biases at OUT_LEN*IN_LEN+j.
REQ-010 SHALL have port w_data, input, signed 32, meaning parameter write data.
REQ-011 SHALL have port busy, output reg, 1, meaning a pass is in progress.
REQ-012 SHALL have port done, output reg, 1, meaning one-cycle pulse when output_fm is valid.
REQ-013 SHALL have port output_fm, output reg, signed 32 x OUT_LEN, meaning neuron results.

Function
REQ-014 SHALL implement states IDLE, BIAS, MAC and WRITE.
REQ-015 In IDLE with start=1: SHALL latch input_fm into an internal copy, set neuron j=0 and busy=1, and go to BIAS.
REQ-016 BIAS: SHALL set the 64-bit accumulator to bias[j] sign-extended and shifted left by FRAC, set k=0, and go to MAC.
REQ-017 MAC: SHALL add the full 64-bit product of latched x[k] and w[j][k] to the accumulator, one term per cycle; after k=IN_LEN-1 it SHALL go to WRITE.
REQ-018 WRITE: SHALL write accumulator arithmetic-shifted right by FRAC, saturated to [0x80000000, 0x7FFFFFFF], into output_fm[j].
REQ-019 WRITE: if j<OUT_LEN-1, SHALL increment j and go to BIAS; otherwise SHALL pulse done=1, clear busy, and go to IDLE.
REQ-020 Latency: done SHALL rise exactly OUT_LEN*(IN_LEN+2) rising edges after the edge that sampled start (44 at defaults).
REQ-021 SHALL ignore start while busy=1; start held high in IDLE after done SHALL begin a new pass.
REQ-022 SHALL apply w_we only when busy=0; it SHALL ignore writes during a pass and writes to addresses at or beyond OUT_LEN*(IN_LEN+1).
REQ-023 output_fm entries SHALL hold their value until overwritten by the next pass.
REQ-024 input_fm changes after the start cycle SHALL NOT affect the current pass.

Reset
REQ-025 rst=0 SHALL immediately force state=IDLE, busy=0, done=0, all output_fm=0, accumulator=0, j=k=0, and all weights and biases to 0, regardless of the current state.
REQ-026 A pass interrupted by reset SHALL NOT produce a done pulse.

Configuration
REQ-027 With macro FC_RELU_EN defined, WRITE SHALL store 0 for any negative saturated result; without it, signed results SHALL pass unchanged.

Verification
REQ-028 Reset: assert rst=0 mid-run -> busy=0, done=0, output_fm all 0 immediately; after release, start -> pass completes normally.
REQ-029 Identity: w[j][j]=256, others 0, biases 0, input_fm=256,512,...,2304 -> output_fm=256,512,768,1024; done at edge 44.
REQ-030 Bias/ReLU: all weights 0, bias[0]=-512, bias[1]=300 -> output_fm[0]=-512 without FC_RELU_EN and 0 with it; output_fm[1]=300.
REQ-031 Saturation: all weights and inputs 0x7FFFFFFF -> all outputs 0x7FFFFFFF; inputs 0x80000001 -> 0x80000000, or 0 with FC_RELU_EN.
REQ-032 Ignored inputs: start pulse and w_we to addr 0 at cycle 10 of a pass -> done still at edge 44, results unchanged, w[0][0] unchanged.

Source files
------------

// File: rtl/fc_layer.sv
// Sequential fully-connected layer: one multiply-accumulate per cycle into a 64-bit accumulator.
// Optional macro FC_RELU_EN clamps negative neuron results to zero.
module fc_layer #(
  parameter int IN_LEN  = 9,
  parameter int OUT_LEN = 4,
  parameter int FRAC    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [32*IN_LEN-1:0]    input_fm,
  input  logic                    w_we,
  input  logic [5:0]              w_addr,
  input  logic [31:0]             w_data,
  output logic                    busy,
  output logic                    done,
  output logic [32*OUT_LEN-1:0]   output_fm
);

  localparam int N_W = OUT_LEN * IN_LEN;
  localparam int N_P = OUT_LEN * (IN_LEN + 1);
  localparam int JW  = $clog2(OUT_LEN + 1);
  localparam int KW  = $clog2(IN_LEN + 1);
  localparam logic signed [63:0] MAX32 = 64'sd2147483647;
  localparam logic signed [63:0] MIN32 = -64'sd2147483648;

  typedef enum logic [1:0] {IDLE, BIAS, MAC, WRITE} state_e;

  state_e             state_q, state_d;
  logic [JW-1:0]      j_q, j_d;
  logic [KW-1:0]      k_q, k_d;
  logic signed [63:0] acc_q, acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic signed [31:0] x_q [IN_LEN];
  logic signed [31:0] x_d [IN_LEN];
  logic signed [31:0] p_q [N_P];
  logic signed [31:0] p_d [N_P];
  logic signed [31:0] y_q [OUT_LEN];
  logic signed [31:0] y_d [OUT_LEN];

  logic signed [63:0] prod;
  logic signed [63:0] shifted;
  logic signed [31:0] sat;
  int                 w_idx;

  function automatic logic signed [63:0] sext64(input logic signed [31:0] v);
    return $signed({{32{v[31]}}, v});
  endfunction

  always_comb begin
    w_idx   = int'(j_q) * IN_LEN + int'(k_q);
    prod    = sext64(x_q[k_q]) * sext64(p_q[w_idx]);
    shifted = acc_q >>> FRAC;
    if (shifted > MAX32)      sat = 32'h7FFF_FFFF;
    else if (shifted < MIN32) sat = 32'h8000_0000;
    else                      sat = shifted[31:0];
`ifdef FC_RELU_EN
    if (sat[31]) sat = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    x_d     = x_q;
    p_d     = p_q;
    y_d     = y_q;

    // Parameter memory is writable only between passes, and only inside its address range.
    if (w_we && !busy_q && (int'(w_addr) < N_P)) p_d[w_addr] = w_data;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int k = 0; k < IN_LEN; k++) x_d[k] = input_fm[32*k +: 32];
          j_d     = '0;
          busy_d  = 1'b1;
          state_d = BIAS;
        end
      end
      BIAS: begin
        acc_d   = sext64(p_q[N_W + int'(j_q)]) <<< FRAC;
        k_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q + prod;
        if (k_q == KW'(IN_LEN - 1)) state_d = WRITE;
        else                        k_d = k_q + 1'b1;
      end
      WRITE: begin
        y_d[j_q] = sat;
        if (j_q < JW'(OUT_LEN - 1)) begin
          j_d     = j_q + 1'b1;
          state_d = BIAS;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use <= so every flop samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      // NOTE: the parameter memory is cleared by reset too, so it must stay in flops, not RAM.
      for (int i = 0; i < IN_LEN; i++)  x_q[i] <= '0;
      for (int i = 0; i < N_P; i++)     p_q[i] <= '0;
      for (int i = 0; i < OUT_LEN; i++) y_q[i] <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      x_q     <= x_d;
      p_q     <= p_d;
      y_q     <= y_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    output_fm = '0;
    for (int j = 0; j < OUT_LEN; j++) output_fm[32*j +: 32] = y_q[j];
  end

endmodule
